arp_rx_parse: RTL and testbench
===============================

ARP_RX_PARSE -- requirements
Module: arp_rx_parse

Interface
REQ-001 Parameter LOCAL_IP, default 32'hC0A8_006E, local IPv4 address matched against the ARP target protocol address.
REQ-002 Parameter LOCAL_MAC, default 48'hABCD_1234_5678, local MAC; informational only, no field check.
REQ-003 logic_clk  input  1  single clock; all logic is rising-edge.
REQ-004 logic_rst  input  1  reset, synchronous, active-high.
REQ-005 arp_rdata_in  input  8  ARP payload byte stream; byte 0 is the first HTYPE byte, Ethernet header already removed.
REQ-006 arp_rvalid_in  input  1  byte valid.
REQ-007 arp_rready_out  output  1  byte accepted when arp_rvalid_in and arp_rready_out are both high.
REQ-008 arp_rlast_in  input  1  marks the last byte of the frame, including padding.
REQ-009 arp_rx_valid_out  output  1  parsed-request record valid.
REQ-010 arp_rx_ready_in  input  1  downstream (ARP reply builder) takes the record.
REQ-011 arp_rx_opcode_out  output  16  OPER field.
REQ-012 arp_rx_smac_out  output  48  sender hardware address (SHA).
REQ-013 arp_rx_sip_out  output  32  sender protocol address (SPA).
REQ-014 arp_drop_cnt_out  output  16  count of frames discarded.

Function
REQ-015 The FSM SHALL have four states: IDLE, RECV, OUT and SKIP.
- IDLE: the next accepted byte is byte 0.
- RECV: receiving bytes 1..N.
- OUT: holding a record.
- SKIP: discarding to end of frame.
REQ-016 arp_rready_out SHALL be 1 in IDLE, RECV and SKIP, and 0 in OUT.
REQ-017 A byte counter SHALL increment on each accepted byte, saturate at 28, and clear on entry to IDLE.
REQ-018 Field capture by byte index (big-endian) SHALL be:
- HTYPE 0-1
- PTYPE 2-3
- HLEN 4
- PLEN 5
- OPER 6-7
- SHA 8-13
- SPA 14-17
- THA 18-23 (ignored)
- TPA 24-27
REQ-019 Bytes with index ≥28 (padding) SHALL be accepted and ignored.
REQ-020 A frame SHALL be accepted only if all of the following hold; otherwise it is dropped:
- at least 28 bytes were received up to and including the rlast byte;
- HTYPE=16'h0001, PTYPE=16'h0800, HLEN=8'h06, PLEN=8'h04;
- OPER is 16'h0001 or 16'h0002;
- TPA=LOCAL_IP.
REQ-021 On the accepted rlast byte:
- if the frame is accepted, the next state is OUT;
- if it is dropped, the next state is IDLE and arp_drop_cnt_out increments by 1, wrapping 16'hFFFF→0.
REQ-022 A single-byte frame (rlast on byte 0 in IDLE) SHALL be dropped, counted, and the FSM SHALL stay in IDLE.
REQ-023 Latency: arp_rx_valid_out SHALL rise on the clock edge that registers the accepted rlast byte (one cycle after that byte is presented).
REQ-024 In OUT, arp_rx_valid_out SHALL stay high and all record outputs SHALL stay stable until arp_rx_ready_in=1; the state then returns to IDLE on the next edge.
REQ-025 If arp_rx_ready_in is already high when OUT is entered, the record SHALL be held exactly one cycle.
REQ-026 Record outputs SHALL update only on entry to OUT; they hold their previous values in every other state.
REQ-027 In IDLE/RECV, a cycle with arp_rvalid_in=0 SHALL not advance the counter; the frame continues.

Reset
REQ-028 While logic_rst=1, the block SHALL force:
- state IDLE, byte counter 0;
- arp_rx_valid_out=0, arp_rx_opcode_out=0, arp_rx_smac_out=0, arp_rx_sip_out=0, arp_drop_cnt_out=0;
- arp_rready_out=0.
REQ-029 On the first cycle after logic_rst falls, if arp_rvalid_in=1 (mid-frame), the FSM SHALL enter SKIP. It accepts and discards bytes up to and including rlast, then goes to IDLE, and does not increment the drop counter.
REQ-030 A reset asserted while in OUT SHALL discard the held record without a handshake.

Verification
REQ-031 Valid request: 28 bytes 0001 0800 06 04 0001 SHA=0011_2233_4455, SPA=C0A8_0001, THA=0, TPA=C0A8_006E, rlast on byte 27, arp_rx_ready_in=1.
- Required: one-cycle valid, opcode 0001, smac 0011_2233_4455, sip C0A8_0001, drop count 0.
REQ-032 Same frame plus 18 padding bytes, rlast on byte 45, with arp_rx_ready_in held 0 for 5 cycles.
- Required: valid rises after byte 45, is held 5 cycles with fields stable, arp_rready_out=0 throughout, and the FSM returns to IDLE after the handshake.
REQ-033 TPA=C0A8_0063 frame -> no valid, arp_drop_cnt_out=1.
REQ-034 OPER=0003 frame -> drop; 20-byte frame with rlast on byte 19 -> drop; resulting arp_drop_cnt_out=2.
REQ-035 Back-to-back valid frames with no idle cycles and arp_rx_ready_in=1 -> two records in order, no byte lost.
REQ-036 Reset asserted at byte 10 and released while arp_rvalid_in=1.
- Required: remaining bytes skipped to rlast, no record, drop count 0.
- The following valid frame is parsed correctly.

Source files
------------

// File: rtl/arp_rx_parse_if.sv
// Byte-stream input and parsed ARP record output of the ARP receive parser.
// master drives the byte stream and takes the record; slave is the parser.
interface arp_rx_parse_if;
  logic [7:0]  arp_rdata_in;
  logic        arp_rvalid_in;
  logic        arp_rready_out;
  logic        arp_rlast_in;
  logic        arp_rx_valid_out;
  logic        arp_rx_ready_in;
  logic [15:0] arp_rx_opcode_out;
  logic [47:0] arp_rx_smac_out;
  logic [31:0] arp_rx_sip_out;
  logic [15:0] arp_drop_cnt_out;

  modport master (
    output arp_rdata_in, arp_rvalid_in, arp_rlast_in, arp_rx_ready_in,
    input  arp_rready_out, arp_rx_valid_out, arp_rx_opcode_out, arp_rx_smac_out,
           arp_rx_sip_out, arp_drop_cnt_out
  );

  modport slave (
    input  arp_rdata_in, arp_rvalid_in, arp_rlast_in, arp_rx_ready_in,
    output arp_rready_out, arp_rx_valid_out, arp_rx_opcode_out, arp_rx_smac_out,
           arp_rx_sip_out, arp_drop_cnt_out
  );
endinterface

// File: rtl/arp_rx_parse.sv
// ARP receive parser: checks each frame byte-by-byte as it streams in and
// presents OPER/SHA/SPA as a held record for frames addressed to LOCAL_IP.
module arp_rx_parse #(
  parameter logic [31:0] LOCAL_IP  = 32'hC0A8_006E,
  parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678
) (
  input logic           logic_clk,
  input logic           logic_rst,
  arp_rx_parse_if.slave arp
);

  typedef enum logic [1:0] {StIdle, StRecv, StOut, StSkip} state_e;

  state_e      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_bad, r_rst_dly;
  logic [15:0] r_opc_sh;
  logic [47:0] r_sha_sh;
  logic [31:0] r_spa_sh;
  logic [15:0] r_opcode, r_drop;
  logic [47:0] r_smac;
  logic [31:0] r_sip;
  logic        w_rready, w_rx_valid, w_acc, w_byte_ok, w_frame_ok, w_drop;
  logic        w_unused_mac;

  assign w_unused_mac = ^LOCAL_MAC;
  assign w_acc        = arp.arp_rvalid_in && w_rready;

  // Check of the current byte against the fixed field value at its index.
  always_comb begin
    w_byte_ok = 1'b1;
    case (r_cnt)
      5'd0:    w_byte_ok = (arp.arp_rdata_in == 8'h00);
      5'd1:    w_byte_ok = (arp.arp_rdata_in == 8'h01);
      5'd2:    w_byte_ok = (arp.arp_rdata_in == 8'h08);
      5'd3:    w_byte_ok = (arp.arp_rdata_in == 8'h00);
      5'd4:    w_byte_ok = (arp.arp_rdata_in == 8'h06);
      5'd5:    w_byte_ok = (arp.arp_rdata_in == 8'h04);
      5'd6:    w_byte_ok = (arp.arp_rdata_in == 8'h00);
      5'd7:    w_byte_ok = (arp.arp_rdata_in == 8'h01) || (arp.arp_rdata_in == 8'h02);
      5'd24:   w_byte_ok = (arp.arp_rdata_in == LOCAL_IP[31:24]);
      5'd25:   w_byte_ok = (arp.arp_rdata_in == LOCAL_IP[23:16]);
      5'd26:   w_byte_ok = (arp.arp_rdata_in == LOCAL_IP[15:8]);
      5'd27:   w_byte_ok = (arp.arp_rdata_in == LOCAL_IP[7:0]);
      default: w_byte_ok = 1'b1;
    endcase
  end

  // Valid only on byte index >= 27, i.e. at least 28 bytes including this one.
  assign w_frame_ok = (r_cnt >= 5'd27) && !r_bad && w_byte_ok;

  always_ff @(posedge logic_clk) begin
    if (logic_rst) r_state <= StIdle;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_acc) begin
          if (r_rst_dly)              w_state_nxt = arp.arp_rlast_in ? StIdle : StSkip;
          else if (!arp.arp_rlast_in) w_state_nxt = StRecv;
        end
      end
      StRecv: begin
        if (w_acc && arp.arp_rlast_in) w_state_nxt = w_frame_ok ? StOut : StIdle;
      end
      StOut: begin
        if (arp.arp_rx_ready_in) w_state_nxt = StIdle;
      end
      StSkip: begin
        if (w_acc && arp.arp_rlast_in) w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    w_rready   = !logic_rst && (r_state != StOut);
    w_rx_valid = !logic_rst && (r_state == StOut);
    w_drop     = w_acc && arp.arp_rlast_in &&
                 (((r_state == StIdle) && !r_rst_dly) || ((r_state == StRecv) && !w_frame_ok));
  end

  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      r_cnt     <= 5'd0;
      r_bad     <= 1'b0;
      r_rst_dly <= 1'b1;
      r_opc_sh  <= 16'h0;
      r_sha_sh  <= 48'h0;
      r_spa_sh  <= 32'h0;
      r_opcode  <= 16'h0;
      r_smac    <= 48'h0;
      r_sip     <= 32'h0;
      r_drop    <= 16'h0;
    end else begin
      r_rst_dly <= 1'b0;
      if (w_state_nxt == StIdle)         r_cnt <= 5'd0;
      else if (w_acc && r_cnt != 5'd28)  r_cnt <= r_cnt + 5'd1;
      if (w_acc) r_bad <= ((r_state == StIdle) ? 1'b0 : r_bad) | !w_byte_ok;
      if (w_acc && r_state != StSkip) begin
        if (r_cnt >= 5'd6 && r_cnt <= 5'd7)   r_opc_sh <= {r_opc_sh[7:0], arp.arp_rdata_in};
        if (r_cnt >= 5'd8 && r_cnt <= 5'd13)  r_sha_sh <= {r_sha_sh[39:0], arp.arp_rdata_in};
        if (r_cnt >= 5'd14 && r_cnt <= 5'd17) r_spa_sh <= {r_spa_sh[23:0], arp.arp_rdata_in};
      end
      // Record is published only when entering OUT so it stays stable while held.
      if (r_state != StOut && w_state_nxt == StOut) begin
        r_opcode <= r_opc_sh;
        r_smac   <= r_sha_sh;
        r_sip    <= r_spa_sh;
      end
      if (w_drop) r_drop <= r_drop + 16'd1;
    end
  end

  assign arp.arp_rready_out    = w_rready;
  assign arp.arp_rx_valid_out  = w_rx_valid;
  assign arp.arp_rx_opcode_out = r_opcode;
  assign arp.arp_rx_smac_out   = r_smac;
  assign arp.arp_rx_sip_out    = r_sip;
  assign arp.arp_drop_cnt_out  = r_drop;

endmodule

// File: tb/tb_arp_rx_parse.sv
// Self-checking bench for arp_rx_parse: directed scenarios plus randomized
// frames scored against a frame-level acceptance model.
module tb_arp_rx_parse;
  localparam logic [31:0] LIP = 32'hC0A8_006E;

  typedef logic [7:0] frame_t[$];
  typedef struct packed {
    logic [15:0] op;
    logic [47:0] mac;
    logic [31:0] ip;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arp_rx_parse_if arp ();

  arp_rx_parse #(
    .LOCAL_IP (LIP),
    .LOCAL_MAC(48'hABCD_1234_5678)
  ) dut (
    .logic_clk(clk),
    .logic_rst(rst),
    .arp      (arp)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   vcyc = 0;
  int   exp_drop = 0;
  rec_t got_q[$];
  rec_t exp_q[$];

  // Records are taken on the edge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (arp.arp_rx_valid_out === 1'b1) vcyc++;
    if (arp.arp_rx_valid_out === 1'b1 && arp.arp_rx_ready_in === 1'b1)
      got_q.push_back({arp.arp_rx_opcode_out, arp.arp_rx_smac_out, arp.arp_rx_sip_out});
  end

  function automatic frame_t make_frame(input logic [15:0] op, input logic [47:0] sha,
                                        input logic [31:0] spa, input logic [31:0] tpa,
                                        input int npad);
    frame_t f;
    f.push_back(8'h00); f.push_back(8'h01); f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h06); f.push_back(8'h04); f.push_back(op[15:8]); f.push_back(op[7:0]);
    for (int i = 5; i >= 0; i--) f.push_back(sha[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) f.push_back(spa[i*8 +: 8]);
    repeat (6) f.push_back(8'h00);
    for (int i = 3; i >= 0; i--) f.push_back(tpa[i*8 +: 8]);
    repeat (npad) f.push_back(8'($urandom_range(0, 255)));
    return f;
  endfunction

  function automatic bit model_ok(input frame_t f);
    logic [15:0] oper;
    if (f.size() < 28) return 1'b0;
    if ({f[0], f[1]} != 16'h0001 || {f[2], f[3]} != 16'h0800) return 1'b0;
    if (f[4] != 8'h06 || f[5] != 8'h04) return 1'b0;
    oper = {f[6], f[7]};
    if (oper != 16'h0001 && oper != 16'h0002) return 1'b0;
    if ({f[24], f[25], f[26], f[27]} != LIP) return 1'b0;
    return 1'b1;
  endfunction

  function automatic rec_t model_rec(input frame_t f);
    rec_t r;
    r.op  = {f[6], f[7]};
    r.mac = {f[8], f[9], f[10], f[11], f[12], f[13]};
    r.ip  = {f[14], f[15], f[16], f[17]};
    return r;
  endfunction

  task automatic push_expect(input frame_t f);
    if (model_ok(f)) exp_q.push_back(model_rec(f));
    else             exp_drop++;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int   n;
    logic acc;
    n = 0;
    arp.arp_rdata_in  = d;
    arp.arp_rvalid_in = 1'b1;
    arp.arp_rlast_in  = last;
    forever begin
      @(negedge clk);
      acc = arp.arp_rready_out;
      @(posedge clk); #1;
      if (acc === 1'b1) break;
      n++;
      if (n > 200) begin
        n_checks++; n_fail++;
        $display("FAIL byte_accept_timeout: rready=%b, required 1 within 200 cycles", acc);
        break;
      end
    end
  endtask

  task automatic send_frame(input frame_t f, input bit gaps, input bit keep);
    for (int i = 0; i < f.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        arp.arp_rvalid_in = 1'b0;
        arp.arp_rlast_in  = 1'b0;
        arp.arp_rdata_in  = 8'($urandom_range(0, 255));
        idle_cycles($urandom_range(1, 2));
      end
      send_byte(f[i], i == f.size() - 1);
    end
    if (!keep) begin
      arp.arp_rvalid_in = 1'b0;
      arp.arp_rlast_in  = 1'b0;
    end
  endtask

  task automatic do_reset();
    arp.arp_rvalid_in = 1'b0;
    arp.arp_rlast_in  = 1'b0;
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(1);
    got_q.delete();
    exp_q.delete();
    exp_drop = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arp.arp_rvalid_in = 1'b0;
    arp.arp_rx_ready_in = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    n_checks++; if (arp.arp_rready_out !== 1'b0) begin n_fail++;
      $display("FAIL reset_rready: got %b required 0", arp.arp_rready_out); end
    n_checks++; if (arp.arp_rx_valid_out !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %b required 0", arp.arp_rx_valid_out); end
    n_checks++; if (arp.arp_rx_opcode_out !== 16'h0) begin n_fail++;
      $display("FAIL reset_opcode: got %h required 0", arp.arp_rx_opcode_out); end
    n_checks++; if (arp.arp_rx_smac_out !== 48'h0) begin n_fail++;
      $display("FAIL reset_smac: got %h required 0", arp.arp_rx_smac_out); end
    n_checks++; if (arp.arp_rx_sip_out !== 32'h0) begin n_fail++;
      $display("FAIL reset_sip: got %h required 0", arp.arp_rx_sip_out); end
    n_checks++; if (arp.arp_drop_cnt_out !== 16'h0) begin n_fail++;
      $display("FAIL reset_drop: got %h required 0", arp.arp_drop_cnt_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1);
    @(negedge clk);
    n_checks++; if (arp.arp_rready_out !== 1'b1) begin n_fail++;
      $display("FAIL idle_rready: got %b required 1", arp.arp_rready_out); end
    got_q.delete();
  endtask

  task automatic test_valid_request();
    frame_t f;
    do_reset();
    arp.arp_rx_ready_in = 1'b1;
    f = make_frame(16'h0001, 48'h0011_2233_4455, 32'hC0A8_0001, LIP, 0);
    push_expect(f);
    vcyc = 0;
    send_frame(f, 1'b0, 1'b0);
    idle_cycles(5);
    n_checks++; if (got_q.size() !== 1) begin n_fail++;
      $display("FAIL valid_req_count: got %0d records required 1", got_q.size()); end
    n_checks++; if (got_q.size() < 1 || got_q[0] !== rec_t'({16'h0001, 48'h0011_2233_4455,
                                                          32'hC0A8_0001})) begin n_fail++;
      $display("FAIL valid_req_record: got %h required %h", got_q.size() ? got_q[0] : '0,
               rec_t'({16'h0001, 48'h0011_2233_4455, 32'hC0A8_0001})); end
    n_checks++; if (vcyc !== 1) begin n_fail++;
      $display("FAIL valid_req_cycles: got %0d valid cycles required 1", vcyc); end
    n_checks++; if (arp.arp_drop_cnt_out !== 16'(exp_drop)) begin n_fail++;
      $display("FAIL valid_req_drop: got %0d required %0d", arp.arp_drop_cnt_out, exp_drop); end
  endtask

  task automatic test_held_record();
    frame_t f;
    rec_t   e, o;
    do_reset();
    arp.arp_rx_ready_in = 1'b0;
    f = make_frame(16'h0001, 48'h0011_2233_4455, 32'hC0A8_0001, LIP, 18);
    e = model_rec(f);
    send_frame(f, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      o = {arp.arp_rx_opcode_out, arp.arp_rx_smac_out, arp.arp_rx_sip_out};
      n_checks++; if (arp.arp_rx_valid_out !== 1'b1) begin n_fail++;
        $display("FAIL hold_valid[%0d]: got %b required 1", c, arp.arp_rx_valid_out); end
      n_checks++; if (arp.arp_rready_out !== 1'b0) begin n_fail++;
        $display("FAIL hold_rready[%0d]: got %b required 0", c, arp.arp_rready_out); end
      n_checks++; if (o !== e) begin n_fail++;
        $display("FAIL hold_fields[%0d]: got %h required %h", c, o, e); end
    end
    @(posedge clk); #1;
    arp.arp_rx_ready_in = 1'b1;
    @(negedge clk);
    n_checks++; if (arp.arp_rx_valid_out !== 1'b1) begin n_fail++;
      $display("FAIL hold_valid_at_handshake: got %b required 1", arp.arp_rx_valid_out); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (arp.arp_rx_valid_out !== 1'b0 || arp.arp_rready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_back_to_idle: got valid=%b rready=%b required valid=0 rready=1",
               arp.arp_rx_valid_out, arp.arp_rready_out); end
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== e) begin n_fail++;
      $display("FAIL hold_record: got %0d records required 1 of %h", got_q.size(), e); end
  endtask

  task automatic test_drops();
    frame_t f;
    do_reset();
    arp.arp_rx_ready_in = 1'b1;
    f = make_frame(16'h0001, 48'h0011_2233_4455, 32'hC0A8_0001, 32'hC0A8_0063, 0);
    push_expect(f);
    send_frame(f, 1'b0, 1'b0);
    idle_cycles(4);
    n_checks++; if (arp.arp_drop_cnt_out !== 16'(exp_drop) || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL drop_tpa: got drop=%0d records=%0d required drop=%0d records=0",
               arp.arp_drop_cnt_out, got_q.size(), exp_drop); end
    do_reset();
    f = make_frame(16'h0003, 48'h0011_2233_4455, 32'hC0A8_0001, LIP, 0);
    push_expect(f);
    send_frame(f, 1'b0, 1'b0);
    f = make_frame(16'h0001, 48'h0011_2233_4455, 32'hC0A8_0001, LIP, 0);
    f = f[0:19];
    push_expect(f);
    send_frame(f, 1'b0, 1'b0);
    idle_cycles(4);
    n_checks++; if (arp.arp_drop_cnt_out !== 16'(exp_drop) || got_q.size() !== 0) begin
      n_fail++;
      $display("FAIL drop_oper_short: got drop=%0d records=%0d required drop=%0d records=0",
               arp.arp_drop_cnt_out, got_q.size(), exp_drop); end
    // Single-byte frame, then a good frame must still parse.
    f = {};
    f.push_back(8'h00);
    push_expect(f);
    send_frame(f, 1'b0, 1'b1);
    f = make_frame(16'h0002, 48'h0A0B_0C0D_0E0F, 32'h0A00_0001, LIP, 0);
    push_expect(f);
    send_frame(f, 1'b0, 1'b0);
    idle_cycles(4);
    n_checks++; if (arp.arp_drop_cnt_out !== 16'(exp_drop)) begin n_fail++;
      $display("FAIL drop_single_byte: got %0d required %0d", arp.arp_drop_cnt_out, exp_drop); end
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin n_fail++;
      $display("FAIL after_single_byte_record: got %0d records required 1 of %h",
               got_q.size(), exp_q[0]); end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    do_reset();
    arp.arp_rx_ready_in = 1'b1;
    f1 = make_frame(16'h0001, 48'h1111_2222_3333, 32'hC0A8_0101, LIP, 0);
    f2 = make_frame(16'h0002, 48'h4444_5555_6666, 32'hC0A8_0202, LIP, 3);
    push_expect(f1);
    push_expect(f2);
    send_frame(f1, 1'b0, 1'b1);
    send_frame(f2, 1'b0, 1'b0);
    idle_cycles(4);
    n_checks++; if (got_q.size() !== 2) begin n_fail++;
      $display("FAIL b2b_count: got %0d records required 2", got_q.size()); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL b2b_record[%0d]: got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : '0, exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    frame_t f;
    do_reset();
    // Reset while a record is held discards it.
    arp.arp_rx_ready_in = 1'b0;
    f = make_frame(16'h0001, 48'h0011_2233_4455, 32'hC0A8_0001, LIP, 0);
    send_frame(f, 1'b0, 1'b0);
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    arp.arp_rx_ready_in = 1'b1;
    @(negedge clk);
    n_checks++; if (arp.arp_rx_valid_out !== 1'b0 || arp.arp_rx_opcode_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_in_out: got valid=%b opcode=%h required 0/0",
               arp.arp_rx_valid_out, arp.arp_rx_opcode_out); end
    @(posedge clk); #1;
    do_reset();
    arp.arp_rx_ready_in = 1'b1;
    f = make_frame(16'h0001, 48'h0011_2233_4455, 32'hC0A8_0001, LIP, 0);
    for (int i = 0; i < 10; i++) send_byte(f[i], 1'b0);
    arp.arp_rdata_in = f[10];
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    for (int i = 10; i < 28; i++) send_byte(f[i], i == 27);
    arp.arp_rvalid_in = 1'b0;
    arp.arp_rlast_in  = 1'b0;
    idle_cycles(4);
    n_checks++; if (got_q.size() !== 0 || arp.arp_drop_cnt_out !== 16'h0) begin n_fail++;
      $display("FAIL midframe_skip: got records=%0d drop=%0d required 0/0",
               got_q.size(), arp.arp_drop_cnt_out); end
    f = make_frame(16'h0002, 48'h0066_7788_99AA, 32'hC0A8_0005, LIP, 2);
    push_expect(f);
    send_frame(f, 1'b0, 1'b0);
    idle_cycles(4);
    n_checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin n_fail++;
      $display("FAIL midframe_next_record: got %0d records required 1 of %h",
               got_q.size(), exp_q[0]); end
  endtask

  task automatic test_random();
    frame_t f;
    bit     done;
    int     nfr;
    do_reset();
    done = 1'b0;
    nfr  = 40;
    fork
      begin
        for (int k = 0; k < nfr; k++) begin
          int kind;
          logic [15:0] op;
          kind = $urandom_range(0, 7);
          op   = 16'($urandom_range(1, 2));
          f = make_frame(op, {$urandom, 16'($urandom)}, $urandom, LIP, $urandom_range(0, 10));
          case (kind)
            4: begin
              int idx;
              idx = $urandom_range(0, 5);
              f[idx] = f[idx] ^ 8'($urandom_range(1, 255));
            end
            5: begin f[6] = 8'($urandom_range(0, 1)); f[7] = 8'($urandom_range(0, 4)); end
            6: f = f[0:$urandom_range(0, 26)];
            7: f[27] = f[27] ^ 8'($urandom_range(1, 255));
            default: ;
          endcase
          push_expect(f);
          send_frame(f, 1'b1, (k != nfr - 1) && ($urandom_range(0, 1) == 1));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          arp.arp_rx_ready_in = 1'($urandom_range(0, 1));
        end
      end
    join
    arp.arp_rx_ready_in = 1'b1;
    idle_cycles(6);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++;
      $display("FAIL random_count: got %0d records required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++;
        $display("FAIL random_record[%0d]: got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : '0, exp_q[i]); end
    end
    n_checks++; if (arp.arp_drop_cnt_out !== 16'(exp_drop)) begin n_fail++;
      $display("FAIL random_drop: got %0d required %0d", arp.arp_drop_cnt_out, exp_drop); end
  endtask

  initial begin
    arp.arp_rdata_in    = 8'h00;
    arp.arp_rvalid_in   = 1'b0;
    arp.arp_rlast_in    = 1'b0;
    arp.arp_rx_ready_in = 1'b0;
    #1;
    test_reset();
    test_valid_request();
    test_held_record();
    test_drops();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
